clock_alarm: RTL and testbench

Alarm controller that sits directly downstream of the hour/minute/second clock counter. It consumes the live time, holds a programmable alarm time, and drives a ring output when the alarm time is reached. Ringing times out after a set number of seconds; a limited number of snoozes are allowed. Output feeds the buzzer/LED driver.

---
 rtl/clock_alarm_if.sv | 42 ++++
 rtl/clock_alarm.sv | 129 ++++++++++++
 tb/tb_clock_alarm.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_alarm_if.sv
// clock_alarm_if
//   Bundles the alarm controller's time, control and status signals.
//   master: the side that supplies live time and user requests (clock counter / UI)
//   slave : the alarm controller itself
//   Signals
//     in_h/in_m/in_s    current time from the clock counter
//     arm               level, alarm enabled while 1
//     alarm_set         load set_h/set_m as the stored alarm time
//     set_h/set_m       alarm time to load
//     snooze/stop       single-cycle user requests
//     ring              registered ring output
//     alarm_h/alarm_m   stored alarm time
//     snooze_cnt        snoozes used in the current alarm event
//     state_dbg         raw controller state (IDLE=0, RING=1, SNOOZE=2)
//   There is no valid/ready pair here: every input is sampled on every rising
//   clock edge, and every output is valid in every cycle.
interface clock_alarm_if;
   logic [5:0] in_h;
   logic [5:0] in_m;
   logic [5:0] in_s;
   logic       arm;
   logic       alarm_set;
   logic [5:0] set_h;
   logic [5:0] set_m;
   logic       snooze;
   logic       stop;
   logic       ring;
   logic [5:0] alarm_h;
   logic [5:0] alarm_m;
   logic [1:0] snooze_cnt;
   logic [1:0] state_dbg;

   modport master (
      output in_h, in_m, in_s, arm, alarm_set, set_h, set_m, snooze, stop,
      input  ring, alarm_h, alarm_m, snooze_cnt, state_dbg
   );

   modport slave (
      input  in_h, in_m, in_s, arm, alarm_set, set_h, set_m, snooze, stop,
      output ring, alarm_h, alarm_m, snooze_cnt, state_dbg
   );
endinterface

// File: rtl/clock_alarm.sv
// clock_alarm
//   Alarm controller downstream of the h/m/s clock counter. Holds a
//   programmable alarm time, rings when the live time reaches hh:mm:00 of the
//   alarm, times the ring out after ring_len seconds and allows up to
//   max_snooze snoozes of snooze_len seconds each.
//   Ports
//     clk    rising-edge system clock
//     reset  asynchronous, active-high
//     bus    clock_alarm_if.slave (time in, requests in, ring/status out)
//   All durations are counted in second ticks, a tick being any cycle in
//   which in_s differs from its value in the previous cycle.
module clock_alarm #(
   parameter int         ring_len     = 30,
   parameter int         snooze_len   = 60,
   parameter int         max_snooze   = 3,
   parameter logic [5:0] alarm_init_h = 6'd7,
   parameter logic [5:0] alarm_init_m = 6'd0
) (
   input  logic          clk,
   input  logic          reset,
   clock_alarm_if.slave  bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RING   = 2'd1;
   localparam logic [1:0] SNOOZE = 2'd2;

   localparam logic [8:0] RING_LAST   = 9'(ring_len - 1);
   localparam logic [8:0] SNOOZE_LAST = 9'(snooze_len - 1);
   localparam logic [1:0] MAX_SNZ     = 2'(max_snooze);

   logic [1:0] state, state_nxt;
   logic [8:0] sec_cnt, sec_nxt;
   logic [1:0] snz_q, snz_nxt;
   logic [5:0] prev_s;
   logic [5:0] alarm_h_q, alarm_m_q;
   logic       ring_q, ring_d;
   logic       tick, match;

   assign tick  = (bus.in_s != prev_s);
   assign match = bus.arm && tick && (bus.in_h == alarm_h_q) &&
                  (bus.in_m == alarm_m_q) && (bus.in_s == 6'd0);

   // State register plus the registered outputs and alarm-time storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sec_cnt   <= '0;
         snz_q     <= '0;
         prev_s    <= '0;
         alarm_h_q <= alarm_init_h;
         alarm_m_q <= alarm_init_m;
         ring_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         sec_cnt <= sec_nxt;
         snz_q   <= snz_nxt;
         prev_s  <= bus.in_s;
         ring_q  <= ring_d;
         if (bus.alarm_set) begin
            alarm_h_q <= bus.set_h;
            alarm_m_q <= bus.set_m;
         end
      end
   end

   // Next-state logic. The if/else chain encodes the request priority:
   // !arm, then alarm_set, then stop, then snooze, then tick/timeouts.
   always_comb begin
      state_nxt = state;
      sec_nxt   = sec_cnt;
      snz_nxt   = snz_q;
      if (!bus.arm) begin
         state_nxt = IDLE;
         snz_nxt   = '0;
      end else if (bus.alarm_set) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (match) state_nxt = RING;
            end
            RING: begin
               if (bus.stop) begin
                  state_nxt = IDLE;
                  snz_nxt   = '0;
               end else if (bus.snooze && (snz_q < MAX_SNZ)) begin
                  state_nxt = SNOOZE;
                  snz_nxt   = snz_q + 2'd1;
               end else if (tick) begin
                  // A snooze refused at the limit falls through to here,
                  // so ringing carries on timing normally.
                  if (sec_cnt == RING_LAST) begin
                     state_nxt = IDLE;
                     snz_nxt   = '0;
                  end else begin
                     sec_nxt = sec_cnt + 9'd1;
                  end
               end
            end
            SNOOZE: begin
               if (bus.stop) begin
                  state_nxt = IDLE;
                  snz_nxt   = '0;
               end else if (tick) begin
                  if (sec_cnt == SNOOZE_LAST) state_nxt = RING;
                  else                        sec_nxt   = sec_cnt + 9'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      // Every state change restarts the second count.
      if (state_nxt != state) sec_nxt = '0;
   end

   // Output logic: ring is registered from the next state so it follows the
   // state register exactly, and reset clears it immediately.
   always_comb begin
      ring_d = (state_nxt == RING);
   end

   assign bus.ring       = ring_q;
   assign bus.alarm_h    = alarm_h_q;
   assign bus.alarm_m    = alarm_m_q;
   assign bus.snooze_cnt = snz_q;
   assign bus.state_dbg  = state;

endmodule

// File: tb/tb_clock_alarm.sv
// tb_clock_alarm
//   Self-checking bench for clock_alarm: a table of hand-derived vectors,
//   directed multi-cycle sequences, then random stimulus against a reference
//   model that tracks "ringing / snoozing / ticks remaining".
module tb_clock_alarm;

   localparam int RING_LEN   = 30;
   localparam int SNOOZE_LEN = 60;
   localparam int MAX_SNOOZE = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   clock_alarm_if bus ();

   clock_alarm #(
      .ring_len    (RING_LEN),
      .snooze_len  (SNOOZE_LEN),
      .max_snooze  (MAX_SNOOZE),
      .alarm_init_h(6'd7),
      .alarm_init_m(6'd0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   // bench-side time of day
   int h = 0, m = 0, s = 0;

   // ---------------- reference model ----------------
   bit         m_ring, m_snoozing;
   int         m_left, m_used;
   logic [5:0] m_ah, m_am, m_prev_s;
   logic [14:0] exp_q[$];

   function automatic logic [14:0] pack(bit r, int u, logic [5:0] ah, logic [5:0] am);
      return {r, 2'(u), ah, am};
   endfunction

   task automatic model_reset();
      m_ring = 0; m_snoozing = 0; m_left = 0; m_used = 0;
      m_ah = 6'd7; m_am = 6'd0; m_prev_s = 6'd0;
   endtask

   task automatic model_step();
      bit tick, hit;
      tick = (bus.in_s != m_prev_s);
      hit  = bus.arm && tick && bus.in_h == m_ah && bus.in_m == m_am && bus.in_s == 6'd0;
      if (bus.alarm_set) begin
         m_ah = bus.set_h;
         m_am = bus.set_m;
      end
      if (!bus.arm) begin
         m_ring = 0; m_snoozing = 0; m_used = 0;
      end else if (bus.alarm_set) begin
         m_ring = 0; m_snoozing = 0;
      end else if (m_ring) begin
         if (bus.stop) begin
            m_ring = 0; m_used = 0;
         end else if (bus.snooze && m_used < MAX_SNOOZE) begin
            m_ring = 0; m_snoozing = 1; m_used++; m_left = SNOOZE_LEN;
         end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
               m_ring = 0; m_used = 0;
            end
         end
      end else if (m_snoozing) begin
         if (bus.stop) begin
            m_snoozing = 0; m_used = 0;
         end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
               m_snoozing = 0; m_ring = 1; m_left = RING_LEN;
            end
         end
      end else if (hit) begin
         m_ring = 1; m_left = RING_LEN;
      end
      m_prev_s = bus.in_s;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      logic [14:0] e;
      @(posedge clk);
      if (reset) model_reset();
      else       model_step();
      exp_q.push_back(pack(m_ring, m_used, m_ah, m_am));
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({bus.ring, bus.snooze_cnt, bus.alarm_h, bus.alarm_m} !== e) begin
         n_err++;
         $display("FAIL model: got ring=%0d snz=%0d al=%0d:%0d expected ring=%0d snz=%0d al=%0d:%0d at %0t",
                  bus.ring, bus.snooze_cnt, bus.alarm_h, bus.alarm_m,
                  e[14], e[13:12], e[11:6], e[5:0], $time);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive_time();
      bus.in_h = 6'(h);
      bus.in_m = 6'(m);
      bus.in_s = 6'(s);
   endtask

   task automatic set_time(input int nh, input int nm, input int ns);
      h = nh; m = nm; s = ns;
      drive_time();
      cycle();
   endtask

   task automatic advance(input int n);
      for (int i = 0; i < n; i++) begin
         s++;
         if (s >= 60) begin s = 0; m++; end
         if (m >= 60) begin m = 0; h++; end
         if (h >= 24) h = 0;
         drive_time();
         cycle();
      end
   endtask

   task automatic pulse_snooze();
      bus.snooze = 1'b1; cycle(); bus.snooze = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int h, m, s;
      bit arm, aset;
      int sh, sm;
      bit snz, stp;
      bit e_ring;
      int e_snz, e_ah, e_am;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          h  m  s arm set sh sm snz stp ring snz ah am
      tbl[0]  = '{7, 29, 58, 1, 1, 7, 30, 0, 0, 0, 0, 7, 30};
      tbl[1]  = '{7, 29, 59, 1, 0, 0, 0,  0, 0, 0, 0, 7, 30};
      tbl[2]  = '{7, 30, 0,  1, 0, 0, 0,  0, 0, 1, 0, 7, 30};  // match
      tbl[3]  = '{7, 30, 0,  1, 0, 0, 0,  0, 0, 1, 0, 7, 30};  // held, still ringing
      tbl[4]  = '{7, 30, 1,  1, 0, 0, 0,  1, 1, 0, 0, 7, 30};  // stop beats snooze
      tbl[5]  = '{7, 30, 2,  1, 0, 0, 0,  0, 0, 0, 0, 7, 30};
      tbl[6]  = '{7, 30, 0,  1, 0, 0, 0,  0, 0, 1, 0, 7, 30};  // jump onto alarm
      tbl[7]  = '{7, 30, 0,  1, 0, 0, 0,  0, 1, 0, 0, 7, 30};  // stop
      tbl[8]  = '{7, 30, 0,  1, 0, 0, 0,  0, 0, 0, 0, 7, 30};  // frozen, no re-ring
      tbl[9]  = '{7, 30, 1,  0, 0, 0, 0,  0, 0, 0, 0, 7, 30};
      tbl[10] = '{7, 30, 0,  0, 0, 0, 0,  0, 0, 0, 0, 7, 30};  // disarmed at match
      tbl[11] = '{7, 30, 1,  1, 0, 0, 0,  1, 0, 0, 0, 7, 30};  // snooze in idle
      tbl[12] = '{7, 30, 0,  1, 1, 7, 30, 0, 0, 0, 0, 7, 30};  // set beats match
      tbl[13] = '{7, 30, 1,  1, 0, 0, 0,  0, 0, 0, 0, 7, 30};

      // ---- reset ----
      reset = 1'b1;
      bus.arm = 1'b0; bus.alarm_set = 1'b0; bus.set_h = '0; bus.set_m = '0;
      bus.snooze = 1'b0; bus.stop = 1'b0;
      h = 0; m = 0; s = 0; drive_time();
      model_reset();
      cycle(); cycle();
      check("rst_ring", bus.ring, 0);
      check("rst_snz", bus.snooze_cnt, 0);
      check("rst_ah", bus.alarm_h, 7);
      check("rst_am", bus.alarm_m, 0);
      reset = 1'b0;
      cycle();

      // ---- table ----
      for (int i = 0; i < 14; i++) begin
         h = tbl[i].h; m = tbl[i].m; s = tbl[i].s; drive_time();
         bus.arm = tbl[i].arm; bus.alarm_set = tbl[i].aset;
         bus.set_h = 6'(tbl[i].sh); bus.set_m = 6'(tbl[i].sm);
         bus.snooze = tbl[i].snz; bus.stop = tbl[i].stp;
         cycle();
         check($sformatf("tbl%0d_ring", i), bus.ring, tbl[i].e_ring);
         check($sformatf("tbl%0d_snz", i), bus.snooze_cnt, tbl[i].e_snz);
         check($sformatf("tbl%0d_ah", i), bus.alarm_h, tbl[i].e_ah);
         check($sformatf("tbl%0d_am", i), bus.alarm_m, tbl[i].e_am);
      end
      bus.arm = 1'b1; bus.alarm_set = 1'b0; bus.snooze = 1'b0; bus.stop = 1'b0;

      // ---- ring timeout after exactly RING_LEN ticks ----
      set_time(7, 29, 59);
      set_time(7, 30, 0);
      check("t1_ring", bus.ring, 1);
      check("t1_snz", bus.snooze_cnt, 0);
      advance(RING_LEN - 1);
      check("t2_ring_last", bus.ring, 1);
      advance(1);
      check("t2_timeout", bus.ring, 0);
      check("t2_state", bus.state_dbg, 0);

      // ---- three snoozes, fourth refused ----
      set_time(7, 29, 59);
      set_time(7, 30, 0);
      for (int i = 1; i <= MAX_SNOOZE; i++) begin
         pulse_snooze();
         check($sformatf("t3_snz%0d_ring", i), bus.ring, 0);
         check($sformatf("t3_snz%0d_cnt", i), bus.snooze_cnt, i);
         advance(SNOOZE_LEN - 1);
         check($sformatf("t3_snz%0d_quiet", i), bus.ring, 0);
         advance(1);
         check($sformatf("t3_snz%0d_rering", i), bus.ring, 1);
      end
      pulse_snooze();
      check("t3_refused_ring", bus.ring, 1);
      check("t3_refused_cnt", bus.snooze_cnt, 3);
      advance(RING_LEN);
      check("t3_timeout_ring", bus.ring, 0);
      check("t3_timeout_cnt", bus.snooze_cnt, 0);

      // ---- stop with two snoozes used, then ring again ----
      set_time(7, 29, 59);
      set_time(7, 30, 0);
      for (int i = 0; i < 2; i++) begin
         pulse_snooze();
         advance(SNOOZE_LEN);
      end
      check("t4_pre_cnt", bus.snooze_cnt, 2);
      pulse_stop();
      check("t4_stop_ring", bus.ring, 0);
      check("t4_stop_cnt", bus.snooze_cnt, 0);
      set_time(7, 29, 59);
      set_time(7, 30, 0);
      check("t4_again", bus.ring, 1);

      // ---- asynchronous reset mid-snooze ----
      pulse_snooze();
      advance(5);
      reset = 1'b1;
      #1;
      model_reset();
      check("t6_ring", bus.ring, 0);
      check("t6_cnt", bus.snooze_cnt, 0);
      check("t6_ah", bus.alarm_h, 7);
      check("t6_am", bus.alarm_m, 0);
      cycle();
      reset = 1'b0;
      set_time(6, 59, 59);
      set_time(7, 0, 0);
      check("t6_init_alarm", bus.ring, 1);

      // ---- random stimulus against the model ----
      for (int i = 0; i < 4000; i++) begin
         int r;
         bus.snooze = 1'b0; bus.stop = 1'b0; bus.alarm_set = 1'b0;
         if ($urandom_range(0, 99) < 2) bus.arm = ~bus.arm;
         r = $urandom_range(0, 99);
         if (r < 4) bus.snooze = 1'b1;
         else if (r < 6) bus.stop = 1'b1;
         else if (r < 7 && bus.arm) begin
            bus.alarm_set = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
               bus.set_h = 6'($urandom_range(0, 63));
               bus.set_m = 6'($urandom_range(0, 63));
            end else begin
               bus.set_h = 6'($urandom_range(6, 8));
               bus.set_m = 6'($urandom_range(28, 32));
            end
         end
         r = $urandom_range(0, 99);
         if (r < 50) begin
            drive_time();
            cycle();
         end else if (r < 96) begin
            advance(1);
         end else begin
            h = int'(m_ah); m = int'(m_am);
            s = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(57, 59));
            drive_time();
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
